conv_window_mac: RTL

//  Downstream compute stage of the 2-D convolution path. Takes one 5-pixel image column per beat

---
 rtl/conv_window_mac_if.sv | 30 +++
 rtl/conv_window_mac.sv | 139 +++++++++++++
 2 files changed

// File: rtl/conv_window_mac_if.sv
`default_nettype none
//==============================================================================
// conv_window_mac_if : kernel-load, column-stream and result bus of the MAC.
// Rev 1.0
//==============================================================================
interface conv_window_mac_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 32
);
   logic [COEF_W-1:0]   kernal_input;
   logic                kernal_valid;
   logic                kernal_reload;
   logic                kernal_complete;
   logic [5*DATA_W-1:0] col_in;
   logic                col_valid;
   logic [OUT_W-1:0]    conv_out;
   logic                conv_valid;

   modport master (
      output kernal_input, kernal_valid, kernal_reload, col_in, col_valid,
      input  kernal_complete, conv_out, conv_valid
   );

   modport slave (
      input  kernal_input, kernal_valid, kernal_reload, col_in, col_valid,
      output kernal_complete, conv_out, conv_valid
   );
endinterface
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
//==============================================================================
// conv_window_mac : 5x5 sliding-window signed MAC, 3-stage pipe, saturated out.
// Rev 1.0
//==============================================================================
module conv_window_mac #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int IMG_W  = 28,
   parameter int OUT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   conv_window_mac_if.slave bus
);
   localparam int                 C_PROD_W    = DATA_W + COEF_W;
   localparam int                 C_SUM_W     = C_PROD_W + 5;
   localparam int                 C_CNT_W     = $clog2(IMG_W);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(IMG_W - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_FIRST = C_CNT_W'(4);
   localparam logic [4:0]         C_COEF_LAST = 5'd24;

   typedef enum logic [0:0] {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

   state_t                     r_state, w_state_nx;
   logic                       w_coef_wr, w_accept;
   logic [4:0]                 r_coef_idx;
   logic [C_CNT_W-1:0]         r_col_cnt;
   logic signed [COEF_W-1:0]   r_coef   [25];
   logic signed [DATA_W-1:0]   r_win    [5][5];
   logic signed [DATA_W-1:0]   w_win_nx [5][5];
   logic signed [C_PROD_W-1:0] w_prod   [25];
   logic signed [C_PROD_W-1:0] r_prod   [25];
   logic signed [C_SUM_W-1:0]  w_row    [5];
   logic signed [C_SUM_W-1:0]  r_row    [5];
   logic signed [C_SUM_W-1:0]  w_total;
   logic [C_SUM_W-OUT_W:0]     w_hi;
   logic [OUT_W-1:0]           w_sat;
   logic [OUT_W-1:0]           r_out;
   logic                       r_v1, r_v2, r_v3;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_LOAD;
      else        r_state <= w_state_nx;
   end

   // Reload has priority over both a coefficient write and a column.
   always_comb begin
      w_state_nx = r_state;
      w_coef_wr  = 1'b0;
      w_accept   = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (!bus.kernal_reload && bus.kernal_valid) begin
               w_coef_wr = 1'b1;
               if (r_coef_idx == C_COEF_LAST) w_state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.kernal_reload) w_state_nx = S_LOAD;
            else                   w_accept   = bus.col_valid;
         end
         default: w_state_nx = S_LOAD;
      endcase
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) w_win_nx[r][c] = r_win[r][c+1];
         w_win_nx[r][4] = bus.col_in[DATA_W*r +: DATA_W];
      end
      for (int i = 0; i < 25; i++)
         w_prod[i] = C_PROD_W'(w_win_nx[i/5][i%5]) * C_PROD_W'(r_coef[i]);
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         w_row[r] = '0;
         for (int c = 0; c < 5; c++) w_row[r] = w_row[r] + C_SUM_W'(r_prod[r*5+c]);
      end
      w_total = '0;
      for (int r = 0; r < 5; r++) w_total = w_total + r_row[r];
   end

   // In range when every bit above the output sign bit matches it.
   always_comb begin
      w_hi = w_total[C_SUM_W-1:OUT_W-1];
      if ((&w_hi) || (~|w_hi)) w_sat = w_total[OUT_W-1:0];
      else if (w_total[C_SUM_W-1]) w_sat = {1'b1, {(OUT_W-1){1'b0}}};
      else w_sat = {1'b0, {(OUT_W-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_coef_idx <= '0;
         r_col_cnt  <= '0;
         for (int i = 0; i < 25; i++) r_coef[i] <= '0;
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) r_win[r][c] <= '0;
      end else begin
         if (w_coef_wr) begin
            r_coef[r_coef_idx] <= bus.kernal_input;
            r_coef_idx         <= (r_coef_idx == C_COEF_LAST) ? 5'd0 : r_coef_idx + 5'd1;
         end
         if (bus.kernal_reload) begin
            r_coef_idx <= '0;
            r_col_cnt  <= '0;
            for (int r = 0; r < 5; r++)
               for (int c = 0; c < 5; c++) r_win[r][c] <= '0;
         end else if (w_accept) begin
            r_win     <= w_win_nx;
            r_col_cnt <= (r_col_cnt == C_CNT_LAST) ? '0 : r_col_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 25; i++) r_prod[i] <= '0;
         for (int r = 0; r < 5; r++) r_row[r] <= '0;
         r_out <= '0;
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
      end else begin
         r_v1 <= w_accept && (r_col_cnt >= C_CNT_FIRST);
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (w_accept) r_prod <= w_prod;
         if (r_v1)     r_row  <= w_row;
         if (r_v2)     r_out  <= w_sat;
      end
   end

   assign bus.kernal_complete = (r_state == S_RUN);
   assign bus.conv_out        = r_out;
   assign bus.conv_valid      = r_v3;
endmodule
`default_nettype wire
